// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// One iteration per clock for DATA_WIDTH clocks, then a single-cycle done pulse.
// Handshake: start is sampled only in IDLE. busy is high for the DATA_WIDTH RUN
// cycles. done pulses for one cycle, and result is valid in that cycle and held
// until the next accepted start. start is ignored in RUN and DONE.
module muldiv_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            funct3,
  input  logic [DATA_WIDTH-1:0] op_a,
  input  logic [DATA_WIDTH-1:0] op_b,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] result,
  output logic [1:0]            state_dbg
);

  localparam int W = DATA_WIDTH;
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q, state_d;

  logic [2:0]           f3_q;
  logic [W-1:0]         raw_a_q;   // original dividend, returned as remainder on divide-by-zero
  logic                 sa_q, sb_q; // effective operand signs
  logic [W-1:0]         a_q;       // |a| (multiplicand), or dividend shifting into quotient
  logic [W-1:0]         b_q;       // |b| (divisor); multiplier lives in acc_q low half
  logic [2*W-1:0]       acc_q;     // {partial product, multiplier} or {0, remainder}
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [W-1:0]         result_q;

  // Operand sign/magnitude decode for the request being presented.
  logic         in_sa_en, in_sb_en, in_sa, in_sb;
  logic [W-1:0] in_mag_a, in_mag_b;

  // One iteration of the datapath.
  logic [W:0]     mul_sum;
  logic [2*W-1:0] mul_acc;
  logic [W:0]     div_shift, div_sub;
  logic           div_ge;
  logic [W-1:0]   div_rem, div_quo;
  logic [2*W-1:0] step_acc;
  logic [W-1:0]   step_a;

  // Final sign correction and result selection.
  logic [2*W-1:0] prod_s;
  logic           b_zero;
  logic [W-1:0]   quo_fix, rem_fix, final_res;
  logic           unused_div_msb;

  // Decode which operands are signed and form their magnitudes.
  always_comb begin
    in_sa_en = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
    in_sb_en = funct3[2] ? ~funct3[0] : ~funct3[1];
    in_sa    = in_sa_en & op_a[W-1];
    in_sb    = in_sb_en & op_b[W-1];
    in_mag_a = in_sa ? -op_a : op_a;
    in_mag_b = in_sb ? -op_b : op_b;
  end

  // Shift-add multiply step and restoring divide step; f3_q[2] selects divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*W-1:W]} + (acc_q[0] ? {1'b0, a_q} : '0);
    mul_acc   = {mul_sum, acc_q[W-1:1]};
    div_shift = {acc_q[W-1:0], a_q[W-1]};
    div_sub   = div_shift - {1'b0, b_q};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_rem   = div_ge ? div_sub[W-1:0] : div_shift[W-1:0];
    div_quo   = {a_q[W-2:0], div_ge};
    step_acc  = f3_q[2] ? {{W{1'b0}}, div_rem} : mul_acc;
    step_a    = f3_q[2] ? div_quo : a_q;
  end

  assign unused_div_msb = div_sub[W];

  // Sign correction applied on the last iteration, plus the divide special cases.
  // Signed overflow (-2**(W-1) / -1) falls out naturally: the magnitude quotient
  // is 2**(W-1), both signs are set so no negation, and the remainder is 0.
  always_comb begin
    prod_s  = (sa_q ^ sb_q) ? -mul_acc : mul_acc;
    b_zero  = (b_q == '0);
    quo_fix = b_zero ? '1 : ((sa_q ^ sb_q) ? -div_quo : div_quo);
    rem_fix = b_zero ? raw_a_q : (sa_q ? -div_rem : div_rem);
    case (f3_q)
      3'b000:                 final_res = prod_s[W-1:0];
      3'b001, 3'b010, 3'b011: final_res = prod_s[2*W-1:W];
      3'b100, 3'b101:         final_res = quo_fix;
      default:                final_res = rem_fix;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> RUN on start, RUN -> DONE after the last iteration.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (cnt_q == LAST_CNT) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state only.
  always_comb begin
    busy      = (state_q == S_RUN);
    done      = (state_q == S_DONE);
    state_dbg = state_q;
  end

  // Datapath: latch operands on accept, iterate in RUN, write result on the last step.
  always_ff @(posedge clk) begin
    if (rst) begin
      f3_q     <= '0;
      raw_a_q  <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            f3_q    <= funct3;
            raw_a_q <= op_a;
            sa_q    <= in_sa;
            sb_q    <= in_sb;
            a_q     <= in_mag_a;
            b_q     <= in_mag_b;
            acc_q   <= funct3[2] ? '0 : {{W{1'b0}}, in_mag_b};
            cnt_q   <= '0;
          end
        end
        S_RUN: begin
          acc_q <= step_acc;
          a_q   <= step_a;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_CNT) result_q <= final_res;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: directed vector table, hand-written corner
// sequences (start while busy, start in DONE, reset mid-operation) and
// random operations checked against an arithmetic reference model.
module tb_muldiv_unit;

  localparam int W = 32;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [2:0]   funct3;
  logic [W-1:0] op_a, op_b;
  logic         busy, done;
  logic [W-1:0] result;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  muldiv_unit #(.DATA_WIDTH(32), .CNT_WIDTH(6)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .funct3    (funct3),
    .op_a      (op_a),
    .op_b      (op_b),
    .busy      (busy),
    .done      (done),
    .result    (result),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  string f3_name[8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: plain 64-bit arithmetic following the RV32M rules.
  function automatic logic [W-1:0] ref_model(input logic [2:0] f3, input logic [W-1:0] a,
                                             input logic [W-1:0] b);
    longint     sa, sb, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(sa * ub); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        return 32'(sa / sb);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(sa % sb);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Called in an IDLE cycle (at the falling edge). Issues one operation, scrambles
  // the inputs while it runs, optionally pulses start again in cycle poke_cyc
  // (1..33), and returns in the first IDLE cycle after done.
  task automatic run_op(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] exp, input string tag, input int poke_cyc);
    bit           lat_ok;
    logic [W-1:0] want;
    lat_ok = 1'b1;
    want   = '0;
    exp_q.push_back(exp);
    start  = 1'b1;
    funct3 = f3;
    op_a   = a;
    op_b   = b;
    @(posedge clk);
    @(negedge clk);
    for (int c = 1; c <= 33; c++) begin
      if (c <= 32) begin
        if (busy !== 1'b1 || done !== 1'b0) lat_ok = 1'b0;
      end else begin
        if (busy !== 1'b0 || done !== 1'b1) lat_ok = 1'b0;
        want = exp_q.pop_front();
        check($sformatf("%s result", tag), 64'(result), 64'(want));
      end
      start  = (c == poke_cyc);
      funct3 = 3'($urandom_range(0, 7));
      op_a   = $urandom;
      op_b   = $urandom;
      @(negedge clk);
    end
    start = 1'b0;
    if (busy !== 1'b0 || done !== 1'b0 || result !== want) lat_ok = 1'b0;
    check($sformatf("%s timing", tag), 64'(lat_ok), 64'd1);
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h1;
      4:       return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]   f3;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] exp;
  } vec_t;

  vec_t vecs[$];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [2:0]   f3;
    logic [W-1:0] a, b;
    bit           quiet;

    vecs.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000});
    vecs.push_back('{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE});
    vecs.push_back('{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF});
    vecs.push_back('{3'd0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{3'd1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{3'd4, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFD});
    vecs.push_back('{3'd6, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF});
    vecs.push_back('{3'd5, 32'd100,        32'd7,          32'd14});
    vecs.push_back('{3'd7, 32'd100,        32'd7,          32'd2});
    vecs.push_back('{3'd4, 32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD});
    vecs.push_back('{3'd6, 32'd7,          32'hFFFF_FFFE, 32'd1});
    vecs.push_back('{3'd4, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{3'd6, 32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB});
    vecs.push_back('{3'd5, 32'd5,          32'd0,          32'hFFFF_FFFF});
    vecs.push_back('{3'd7, 32'd5,          32'd0,          32'd5});
    vecs.push_back('{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000});
    vecs.push_back('{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0});

    // Reset.
    rst = 1'b1; start = 1'b0; funct3 = '0; op_a = '0; op_b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset busy",   64'(busy),      64'd0);
    check("reset done",   64'(done),      64'd0);
    check("reset result", 64'(result),    64'd0);
    check("reset state",  64'(state_dbg), 64'd0);

    // Directed table.
    for (int i = 0; i < vecs.size(); i++)
      run_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].exp,
             $sformatf("vec%0d %s", i, f3_name[vecs[i].f3]), 0);

    // start pulsed mid-DIV with a different op_a is ignored; then a new op is accepted.
    run_op(3'd4, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, "DIV poke busy", 5);
    // start held during the DONE cycle is ignored.
    run_op(3'd5, 32'd50, 32'd7, 32'd7, "DIVU poke done", 33);
    run_op(3'd7, 32'd50, 32'd7, 32'd1, "REMU after poke", 0);

    // Reset in cycle 10 of a MUL aborts it with no done pulse.
    start = 1'b1; funct3 = 3'd0; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid-op busy before rst", 64'(busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst abort busy",   64'(busy),      64'd0);
    check("rst abort done",   64'(done),      64'd0);
    check("rst abort result", 64'(result),    64'd0);
    check("rst abort state",  64'(state_dbg), 64'd0);
    quiet = 1'b1;
    for (int c = 11; c <= 40; c++) begin
      if (done !== 1'b0 || busy !== 1'b0 || result !== '0) quiet = 1'b0;
      @(negedge clk);
    end
    check("rst abort quiet", 64'(quiet), 64'd1);

    // Random operations against the reference model.
    for (int n = 0; n < 150; n++) begin
      f3 = 3'($urandom_range(0, 7));
      a  = rand_operand();
      b  = rand_operand();
      run_op(f3, a, b, ref_model(f3, a, b),
             $sformatf("rand%0d %s 0x%0h,0x%0h", n, f3_name[f3], a, b), 0);
    end

    check("scoreboard drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
